// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared FSM type and constants for the req/ack bus arbiter
package bus_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
   localparam int PRIO_RR = 0;
   localparam int PRIO_FIXED = 1;
   localparam logic [63:0] TIMEOUT_RDATA = '0;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner select, round-robin from ptr or lowest index
module arb_pick #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         mode,
   output logic         valid,
   output logic [W-1:0] idx
);
   // walk candidates from farthest to nearest so the nearest requester wins
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         automatic int j = mode ? i : (int'(ptr) + i) % N;
         if (req[j]) idx = W'(j);
      end
   end
   assign valid = |req;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master to 1-slave req/ack arbiter, round-robin or fixed
// priority, with an optional watchdog that error-acks hung slave accesses.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int NUM_PORTS      = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int PRIORITY_MODE  = 0,
   parameter int TIMEOUT_CYCLES = 0,
   localparam int GW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1,
   localparam int MW = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      rstz,
   input  logic [NUM_PORTS-1:0]      m_req,
   input  logic [NUM_PORTS-1:0]      m_wr_en,
   input  logic [NUM_PORTS*ADDR_W-1:0] m_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] m_wdata,
   input  logic [NUM_PORTS*MW-1:0]   m_mask,
   output logic [NUM_PORTS-1:0]      m_ack,
   output logic                      m_err,
   output logic [DATA_W-1:0]         m_rdata,
   output logic                      s_req,
   output logic                      s_wr_en,
   output logic [ADDR_W-1:0]         s_addr,
   output logic [DATA_W-1:0]         s_wdata,
   output logic [MW-1:0]             s_mask,
   input  logic                      s_ack,
   input  logic [DATA_W-1:0]         s_rdata,
   output logic [GW-1:0]             grant_id
);
   localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
   arb_state_t state;
   logic [GW-1:0] rr_ptr, win;
   logic [CW-1:0] cnt;
   logic any_req, timeout;
   arb_pick #(.N(NUM_PORTS), .W(GW)) u_pick (
      .req(m_req),
      .ptr(rr_ptr),
      .mode(PRIORITY_MODE == PRIO_FIXED),
      .valid(any_req),
      .idx(win)
   );
   assign timeout = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST);
   always_ff @(posedge clk or negedge rstz)
      if (!rstz) begin
         state    <= IDLE;
         s_req    <= 1'b0;
         s_wr_en  <= 1'b0;
         s_addr   <= '0;
         s_wdata  <= '0;
         s_mask   <= '0;
         m_ack    <= '0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
         cnt      <= '0;
      end else
         case (state)
            IDLE:
               if (any_req) begin
                  state    <= BUSY;
                  s_req    <= 1'b1;
                  s_wr_en  <= m_wr_en[win];
                  s_addr   <= m_addr[win*ADDR_W +: ADDR_W];
                  s_wdata  <= m_wdata[win*DATA_W +: DATA_W];
                  s_mask   <= m_mask[win*MW +: MW];
                  grant_id <= win;
                  cnt      <= '0;
               end
            // a real ack in the watchdog's last cycle still counts as success
            BUSY:
               if (s_ack || timeout) begin
                  state   <= RESP;
                  s_req   <= 1'b0;
                  m_ack   <= NUM_PORTS'(1) << grant_id;
                  m_err   <= !s_ack;
                  m_rdata <= s_ack ? s_rdata : DATA_W'(TIMEOUT_RDATA);
                  if (s_ack) rr_ptr <= (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
               end else
                  cnt <= cnt + 1'b1;
            default: begin
               state <= IDLE;
               m_ack <= '0;
               m_err <= 1'b0;
            end
         endcase
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven check of round-robin, fixed priority, watchdog and reset
module tb_bus_arbiter;
   typedef struct {
      logic [1:0]  req;
      logic [1:0]  wr;
      int          lat;
      logic [31:0] rdata;
      int          ga;
      int          gf;
      bit          chk_f;
   } vec_t;

   logic        clk = 1'b0, rstz = 1'b0;
   logic [1:0]  m_req = '0, m_wr_en = '0;
   logic [63:0] m_addr = {32'h0000_0100, 32'h0000_0040};
   logic [63:0] m_wdata = {32'h2222_2222, 32'h1111_1111};
   logic [7:0]  m_mask = {4'b0011, 4'b1111};
   logic        s_ack = 1'b0;
   logic [31:0] s_rdata = '0;

   logic [1:0]  a_m_ack, f_m_ack;
   logic        a_m_err, f_m_err, a_s_req, f_s_req, a_s_wr_en, f_s_wr_en;
   logic [31:0] a_m_rdata, f_m_rdata, a_s_addr, f_s_addr, a_s_wdata, f_s_wdata;
   logic [3:0]  a_s_mask, f_s_mask;
   logic        a_gid, f_gid;

   int n_vec = 0, n_err = 0;
   vec_t vt[9];

   always #5 clk = ~clk;

   bus_arbiter #(.NUM_PORTS(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) u_a (
      .clk(clk), .rstz(rstz), .m_req(m_req), .m_wr_en(m_wr_en), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_mask(m_mask), .m_ack(a_m_ack), .m_err(a_m_err),
      .m_rdata(a_m_rdata), .s_req(a_s_req), .s_wr_en(a_s_wr_en), .s_addr(a_s_addr),
      .s_wdata(a_s_wdata), .s_mask(a_s_mask), .s_ack(s_ack), .s_rdata(s_rdata),
      .grant_id(a_gid)
   );

   bus_arbiter #(.NUM_PORTS(2), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(0)) u_f (
      .clk(clk), .rstz(rstz), .m_req(m_req), .m_wr_en(m_wr_en), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_mask(m_mask), .m_ack(f_m_ack), .m_err(f_m_err),
      .m_rdata(f_m_rdata), .s_req(f_s_req), .s_wr_en(f_s_wr_en), .s_addr(f_s_addr),
      .s_wdata(f_s_wdata), .s_mask(f_s_mask), .s_ack(s_ack), .s_rdata(s_rdata),
      .grant_id(f_gid)
   );

   function automatic logic [31:0] paddr(input int p);
      return p != 0 ? 32'h0000_0100 : 32'h0000_0040;
   endfunction

   function automatic logic [31:0] pwdata(input int p);
      return p != 0 ? 32'h2222_2222 : 32'h1111_1111;
   endfunction

   function automatic logic [3:0] pmask(input int p);
      return p != 0 ? 4'b0011 : 4'b1111;
   endfunction

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_sreq(input string name);
      int k = 0;
      do begin
         tick();
         k++;
      end while (!a_s_req && k < 6);
      chk({name, "_sreq_up"}, 128'(a_s_req), 128'(1));
   endtask

   task automatic slave_ack(input int lat, input logic [31:0] rd);
      for (int i = 1; i < lat; i++) tick();
      s_ack = 1'b1;
      s_rdata = rd;
      tick();
      s_ack = 1'b0;
      s_rdata = '0;
   endtask

   task automatic run(input string name, input vec_t r);
      m_req = r.req;
      m_wr_en = r.wr;
      wait_sreq(name);
      chk({name, "_gid"}, 128'(a_gid), 128'(r.ga));
      chk({name, "_saddr"}, 128'(a_s_addr), 128'(paddr(r.ga)));
      chk({name, "_swr"}, 128'(a_s_wr_en), 128'(r.wr[r.ga]));
      chk({name, "_swdata"}, 128'(a_s_wdata), 128'(pwdata(r.ga)));
      chk({name, "_smask"}, 128'(a_s_mask), 128'(pmask(r.ga)));
      if (r.chk_f) chk({name, "_f_gid"}, 128'(f_gid), 128'(r.gf));
      slave_ack(r.lat, r.rdata);
      chk({name, "_mack"}, 128'(a_m_ack), 128'(2'b01 << r.ga));
      chk({name, "_merr"}, 128'(a_m_err), 128'(0));
      chk({name, "_mrdata"}, 128'(a_m_rdata), 128'(r.rdata));
      chk({name, "_sreq_dn"}, 128'(a_s_req), 128'(0));
      if (r.chk_f) chk({name, "_f_mack"}, 128'(f_m_ack), 128'(2'b01 << r.gf));
      tick();
      chk({name, "_mack_clr"}, 128'({a_m_ack, a_m_err}), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      vt[0] = '{2'b10, 2'b00, 3, 32'hCAFE_F00D, 1, 1, 1};
      vt[1] = '{2'b11, 2'b00, 1, 32'h0000_0001, 0, 0, 1};
      vt[2] = '{2'b11, 2'b00, 1, 32'h0000_0002, 1, 0, 1};
      vt[3] = '{2'b11, 2'b00, 1, 32'h0000_0003, 0, 0, 1};
      vt[4] = '{2'b11, 2'b00, 1, 32'h0000_0004, 1, 0, 1};
      vt[5] = '{2'b10, 2'b00, 1, 32'h0000_0005, 1, 1, 1};
      vt[6] = '{2'b01, 2'b01, 2, 32'h0000_0006, 0, 0, 1};
      vt[7] = '{2'b01, 2'b00, 1, 32'h0000_0007, 0, 0, 1};
      vt[8] = '{2'b10, 2'b10, 8, 32'hA5A5_0008, 1, 1, 1};
      tick();
      tick();
      chk("reset_a", {a_s_req, a_s_wr_en, a_s_addr, a_s_wdata, a_s_mask, a_m_ack, a_m_err, a_m_rdata, a_gid}, '0);
      chk("reset_f", {f_s_req, f_m_ack, f_m_err, f_gid}, '0);
      rstz = 1'b1;
      tick();
      foreach (vt[i]) run($sformatf("vec%0d", i), vt[i]);
      // watchdog: slave never answers
      m_req = 2'b01;
      m_wr_en = 2'b00;
      wait_sreq("to");
      n = 0;
      for (int k = 0; k < 20 && a_s_req; k++) begin
         n++;
         tick();
      end
      chk("to_sreq_len", 128'(n), 128'(8));
      chk("to_mack", 128'(a_m_ack), 128'(2'b01));
      chk("to_merr", 128'(a_m_err), 128'(1));
      chk("to_mrdata", 128'(a_m_rdata), 128'(0));
      tick();
      chk("to_mack_clr", 128'({a_m_ack, a_m_err}), 128'(0));
      run("after_to", vec_t'{2'b01, 2'b00, 2, 32'h0BAD_BEEF, 0, 0, 0});
      // reset in the middle of a port1 write
      m_req = 2'b10;
      m_wr_en = 2'b10;
      wait_sreq("rst");
      chk("rst_smask", 128'({a_s_wr_en, a_s_mask}), 128'(5'b1_0011));
      tick();
      #2 rstz = 1'b0;
      #1 chk("rst_mid", {a_s_req, a_s_wr_en, a_s_addr, a_s_wdata, a_s_mask, a_m_ack, a_m_err, a_m_rdata, a_gid}, '0);
      m_req = 2'b11;
      m_wr_en = 2'b00;
      tick();
      rstz = 1'b1;
      wait_sreq("rearb");
      chk("rearb_gid", 128'(a_gid), 128'(0));
      chk("rearb_saddr", 128'(a_s_addr), 128'(32'h40));
      slave_ack(1, 32'h1234_5678);
      chk("rearb_mack", 128'(a_m_ack), 128'(2'b01));
      chk("rearb_mrdata", 128'(a_m_rdata), 128'(32'h1234_5678));
      m_req = 2'b00;
      tick();
      // stray ack while idle
      s_ack = 1'b1;
      s_rdata = 32'hDEAD_DEAD;
      tick();
      s_ack = 1'b0;
      s_rdata = '0;
      chk("spur_mack", 128'({a_m_ack, a_m_err, a_s_req}), 128'(0));
      tick();
      chk("spur_mack2", 128'(a_m_ack), 128'(0));
      chk("spur_mrdata_hold", 128'(a_m_rdata), 128'(32'h1234_5678));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
